fifo36_to_ll8_pipe: RTL and testbench

FIFO36_TO_LL8_PIPE -- requirements
Module: fifo36_to_ll8_pipe

---
 rtl/fifo36_to_ll8_pipe_pkg.sv | 25 ++
 rtl/fifo36_proto_chk.sv | 45 ++++
 rtl/fifo36_to_ll8_pipe.sv | 115 +++++++++++
 tb/tb_fifo36_to_ll8_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo36_to_ll8_pipe_pkg.sv
// Shared definitions for the 36-bit FIFO to 8-bit LocalLink converter:
// word field positions, converter states and the last-byte-index helper.
package fifo36_to_ll8_pipe_pkg;

  localparam int OCC_HI  = 35;
  localparam int OCC_LO  = 34;
  localparam int EOF_BIT = 33;
  localparam int SOF_BIT = 32;
  localparam int DATA_HI = 31;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_e;

  // Index of the final valid byte: a partial word only exists on eof with occ != 0.
  function automatic logic [1:0] last_idx(input logic [35:0] word);
    if (word[EOF_BIT] && (word[OCC_HI:OCC_LO] != 2'd0)) begin
      last_idx = word[OCC_HI:OCC_LO] - 2'd1;
    end else begin
      last_idx = 2'd3;
    end
  endfunction

endpackage

// File: rtl/fifo36_proto_chk.sv
// Framing checker: tracks whether accepted words are inside a frame and raises
// a sticky error on a missing or unexpected start-of-frame.
module fifo36_proto_chk (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic accept_i,
  input  logic sof_i,
  input  logic eof_i,
  output logic proto_err_o
);

  logic in_frame_q, in_frame_d;
  logic err_q, err_d;

  // Next-state: sof must be set exactly when no frame is open.
  always_comb begin
    in_frame_d = in_frame_q;
    err_d      = err_q;
    if (accept_i) begin
      if (sof_i == in_frame_q) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      in_frame_d = ~eof_i;
    end else begin
      in_frame_d = in_frame_q;
    end
  end

  // Tracker and sticky flag registers.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      in_frame_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      in_frame_q <= in_frame_d;
      err_q      <= err_d;
    end
  end

  assign proto_err_o = err_q;

endmodule

// File: rtl/fifo36_to_ll8_pipe.sv
// 36-bit FIFO word to 8-bit LocalLink byte stream, one byte per cycle.
// Optional framing checker enabled by defining FIFO36_TO_LL8_PIPE_PROTO_CHK_EN.
module fifo36_to_ll8_pipe #(
  parameter int LE    = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [35:0]      f36_data,
  input  logic             f36_src_rdy_i,
  output logic             f36_dst_rdy_o,
  output logic [7:0]       ll_data,
  output logic             ll_sof_n,
  output logic             ll_eof_n,
  output logic             ll_src_rdy_n,
  input  logic             ll_dst_rdy_n,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             proto_err
);
  import fifo36_to_ll8_pipe_pkg::*;

  state_e           state_q, state_d;
  logic [35:0]      word_q, word_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] last_s;
  logic       byte_xfer_s;
  logic       last_xfer_s;
  logic       accept_s;
  logic [4:0] shift_s;

  // Handshake decode; a word may load in the same cycle the last byte leaves.
  always_comb begin
    last_s        = last_idx(word_q);
    byte_xfer_s   = (state_q == ST_SEND) && !ll_dst_rdy_n;
    last_xfer_s   = byte_xfer_s && (idx_q == last_s);
    f36_dst_rdy_o = (state_q == ST_EMPTY) || last_xfer_s;
    accept_s      = f36_src_rdy_i && f36_dst_rdy_o;
  end

  // Next-state, byte index and frame counter.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (accept_s) begin
      word_d  = f36_data;
      idx_d   = 2'd0;
      state_d = ST_SEND;
    end else if (last_xfer_s) begin
      idx_d   = 2'd0;
      state_d = ST_EMPTY;
    end else if (byte_xfer_s) begin
      idx_d   = idx_q + 2'd1;
    end else begin
      idx_d   = idx_q;
    end
    if (last_xfer_s && word_q[EOF_BIT]) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control registers; clear behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= ST_EMPTY;
      idx_q   <= 2'd0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Holding register carries no reset; its content is ignored while empty.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  // Byte select: big-endian walks down from the top byte, little-endian walks up.
  always_comb begin
    if (LE != 0) begin
      shift_s = {idx_q, 3'b000};
    end else begin
      shift_s = {~idx_q, 3'b000};
    end
    ll_data      = 8'(word_q[DATA_HI:0] >> shift_s);
    ll_src_rdy_n = (state_q != ST_SEND);
    ll_sof_n     = !((state_q == ST_SEND) && word_q[SOF_BIT] && (idx_q == 2'd0));
    ll_eof_n     = !((state_q == ST_SEND) && word_q[EOF_BIT] && (idx_q == last_s));
  end

  assign frame_cnt = cnt_q;

`ifdef FIFO36_TO_LL8_PIPE_PROTO_CHK_EN
  fifo36_proto_chk u_proto_chk (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .accept_i    (accept_s),
    .sof_i       (f36_data[SOF_BIT]),
    .eof_i       (f36_data[EOF_BIT]),
    .proto_err_o (proto_err)
  );
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo36_to_ll8_pipe.sv
// Randomized + directed bench for fifo36_to_ll8_pipe; big- and little-endian
// instances share stimulus and are checked against a byte-queue reference model.
module tb_fifo36_to_ll8_pipe;

`ifdef FIFO36_TO_LL8_PIPE_PROTO_CHK_EN
  localparam bit PROTO = 1'b1;
`else
  localparam bit PROTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [35:0] f36_data;
  logic        f36_src_rdy_i;
  logic        ll_dst_rdy_n;

  logic        f36_dst_rdy_o, ll_sof_n, ll_eof_n, ll_src_rdy_n, proto_err;
  logic [7:0]  ll_data;
  logic [15:0] frame_cnt;
  logic        f36_dst_rdy_o_le, ll_sof_n_le, ll_eof_n_le, ll_src_rdy_n_le, proto_err_le;
  logic [7:0]  ll_data_le;
  logic [15:0] frame_cnt_le;

  always #5 clk = ~clk;

  fifo36_to_ll8_pipe #(.LE(0), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .f36_data(f36_data),
    .f36_src_rdy_i(f36_src_rdy_i), .f36_dst_rdy_o(f36_dst_rdy_o),
    .ll_data(ll_data), .ll_sof_n(ll_sof_n), .ll_eof_n(ll_eof_n),
    .ll_src_rdy_n(ll_src_rdy_n), .ll_dst_rdy_n(ll_dst_rdy_n),
    .frame_cnt(frame_cnt), .proto_err(proto_err)
  );

  fifo36_to_ll8_pipe #(.LE(1), .CNT_W(16)) u_dut_le (
    .clk(clk), .reset(reset), .clear(clear), .f36_data(f36_data),
    .f36_src_rdy_i(f36_src_rdy_i), .f36_dst_rdy_o(f36_dst_rdy_o_le),
    .ll_data(ll_data_le), .ll_sof_n(ll_sof_n_le), .ll_eof_n(ll_eof_n_le),
    .ll_src_rdy_n(ll_src_rdy_n_le), .ll_dst_rdy_n(ll_dst_rdy_n),
    .frame_cnt(frame_cnt_le), .proto_err(proto_err_le)
  );

  typedef struct {
    logic [7:0] b_be;
    logic [7:0] b_le;
    logic       sof_n;
    logic       eof_n;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        exp_err = 1'b0;
  logic        in_frame = 1'b0;
  int          sink_mode = 0;
  logic        accepted = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  h_data, h_data_le;
  logic        h_sof, h_eof;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expand an accepted word into the bytes the link should carry.
  task automatic push_word(input logic [35:0] w);
    int   n;
    exp_t e;
    n = (w[33] && (w[35:34] != 2'd0)) ? int'(w[35:34]) : 4;
    for (int i = 0; i < n; i++) begin
      e.b_be  = w[31-8*i -: 8];
      e.b_le  = w[8*i +: 8];
      e.sof_n = !(w[32] && (i == 0));
      e.eof_n = !(w[33] && (i == n - 1));
      q.push_back(e);
    end
    if (PROTO && (w[32] == in_frame)) exp_err = 1'b1;
    in_frame = !w[33];
  endtask

  task automatic tick();
    logic xfer, acc, exp_dst;
    exp_t e;
    case (sink_mode)
      0:       ll_dst_rdy_n = 1'b0;
      1:       ll_dst_rdy_n = ~ll_dst_rdy_n;
      default: ll_dst_rdy_n = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    chk("src_rdy_n", ll_src_rdy_n, q.size() == 0);
    chk("src_rdy_n_le", ll_src_rdy_n_le, q.size() == 0);
    exp_dst = (q.size() == 0) || ((q.size() == 1) && !ll_dst_rdy_n);
    chk("f36_dst_rdy", f36_dst_rdy_o, exp_dst);
    chk("f36_dst_rdy_le", f36_dst_rdy_o_le, exp_dst);
    chk("frame_cnt", frame_cnt, exp_cnt);
    chk("frame_cnt_le", frame_cnt_le, exp_cnt);
    chk("proto_err", proto_err, exp_err);
    chk("proto_err_le", proto_err_le, exp_err);
    if (prev_stall) begin
      chk("hold_data", ll_data, h_data);
      chk("hold_data_le", ll_data_le, h_data_le);
      chk("hold_sof", ll_sof_n, h_sof);
      chk("hold_eof", ll_eof_n, h_eof);
    end
    prev_stall = !reset && !clear && !ll_src_rdy_n && ll_dst_rdy_n;
    h_data = ll_data; h_data_le = ll_data_le; h_sof = ll_sof_n; h_eof = ll_eof_n;
    xfer = !ll_src_rdy_n && !ll_dst_rdy_n;
    acc  = f36_src_rdy_i && f36_dst_rdy_o;
    accepted = acc && !reset && !clear;
    if (!reset && !clear) begin
      if (xfer && (q.size() > 0)) begin
        e = q.pop_front();
        chk("byte", ll_data, e.b_be);
        chk("byte_le", ll_data_le, e.b_le);
        chk("sof_n", ll_sof_n, e.sof_n);
        chk("eof_n", ll_eof_n, e.eof_n);
        chk("eof_n_le", ll_eof_n_le, e.eof_n);
        if (!e.eof_n) exp_cnt = exp_cnt + 16'd1;
      end
      if (acc) push_word(f36_data);
    end
    @(posedge clk);
    if (reset || clear) begin
      q.delete();
      exp_cnt  = 16'd0;
      exp_err  = 1'b0;
      in_frame = 1'b0;
      prev_stall = 1'b0;
    end
    #1;
  endtask

  task automatic send_word(input logic [35:0] w);
    f36_data      = w;
    f36_src_rdy_i = 1'b1;
    accepted      = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (accepted) break;
    end
    chk("accept_timeout", {35'd0, accepted}, 36'd1);
    f36_src_rdy_i = 1'b0;
  endtask

  task automatic drain(input int n);
    f36_src_rdy_i = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; f36_src_rdy_i = 1'b0; f36_data = 36'd0;
    ll_dst_rdy_n = 1'b0; sink_mode = 0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_src_rdy_n", ll_src_rdy_n, 36'd1);
    chk("reset_frame_cnt", frame_cnt, 36'd0);
    drain(2);

    // Single full word, big-endian, one frame.
    send_word({2'd0, 1'b1, 1'b1, 32'hAABBCCDD});
    drain(6);
    chk("single_frame_cnt", frame_cnt, 36'd1);

    // Two-word frame ending with a 2-byte partial word, no gap.
    send_word({2'd0, 1'b0, 1'b1, 32'h01020304});
    send_word({2'd2, 1'b1, 1'b0, 32'h0506BEEF});
    drain(8);
    chk("two_word_frame_cnt", frame_cnt, 36'd2);

    // Three valid bytes, little-endian instance gives 44,33,22.
    send_word({2'd3, 1'b1, 1'b1, 32'h11223344});
    drain(6);
    chk("occ3_frame_cnt_le", frame_cnt_le, 36'd3);

    // Sink toggles readiness every cycle.
    sink_mode = 1;
    send_word({2'd0, 1'b0, 1'b1, 32'hCAFEF00D});
    send_word({2'd1, 1'b1, 1'b0, 32'h99887766});
    drain(20);
    sink_mode = 0;

    // Reset after two bytes of a four-byte word, then a fresh frame.
    send_word({2'd0, 1'b0, 1'b1, 32'hDEADBEEF});
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_reset_src_rdy_n", ll_src_rdy_n, 36'd1);
    chk("mid_reset_frame_cnt", frame_cnt, 36'd0);
    send_word({2'd0, 1'b1, 1'b1, 32'h0A0B0C0D});
    drain(6);
    chk("post_reset_frame_cnt", frame_cnt, 36'd1);

    // Clear mid-frame behaves like reset.
    send_word({2'd0, 1'b0, 1'b1, 32'h12345678});
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_src_rdy_n", ll_src_rdy_n, 36'd1);
    chk("clear_frame_cnt", frame_cnt, 36'd0);

    // Start-of-frame inside an open frame; sticky when checker is built in.
    send_word({2'd0, 1'b0, 1'b1, 32'h10203040});
    send_word({2'd0, 1'b0, 1'b1, 32'h50607080});
    send_word({2'd0, 1'b1, 1'b0, 32'h90A0B0C0});
    drain(6);
    chk("proto_err_sticky", proto_err, {35'd0, PROTO});
    reset = 1'b1; tick(); reset = 1'b0;
    chk("proto_err_reset", proto_err, 36'd0);

    // Randomized traffic under random sink behaviour.
    for (int n = 0; n < 300; n++) begin
      logic [35:0] w;
      sink_mode = $urandom_range(0, 2);
      w = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 32'($urandom)};
      send_word(w);
      if ($urandom_range(0, 3) == 0) drain($urandom_range(1, 3));
    end
    sink_mode = 0;
    drain(10);
    chk("final_frame_cnt", frame_cnt, {20'd0, exp_cnt});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
